// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
package matmul_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Smallest result width that holds one full product without wrapping.
  function automatic int unsigned acc_width_min(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Element index of [r][c] in a row-major flat bus.
  function automatic int unsigned flat_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matmul_nxn_seq_if.sv
// Start/done control and operand/result bus of the NxN matrix multiplier.
interface matmul_nxn_seq_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
);
  logic                 start;
  logic                 signed_mode;
  logic                 acc_mode;
  logic [N*N*DW-1:0]    A_flat;
  logic [N*N*DW-1:0]    B_flat;
  logic [N*N*ACC_W-1:0] C_flat;
  logic                 busy;
  logic                 done;

  modport master (
    output start, signed_mode, acc_mode, A_flat, B_flat,
    input  C_flat, busy, done
  );

  modport slave (
    input  start, signed_mode, acc_mode, A_flat, B_flat,
    output C_flat, busy, done
  );
endinterface

// File: rtl/matmul_mac_lane.sv
// One multiply-accumulate lane: extend both operands to ACC_W, multiply, add base, wrap.
module matmul_mac_lane #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [ACC_W-1:0] base,
  input  logic             signed_mode,
  output logic [ACC_W-1:0] sum_c
);
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;

  // Low ACC_W bits of the product are identical for signed and unsigned once extended.
  always_comb begin
    a_ext = {{(ACC_W-DW){signed_mode & a[DW-1]}}, a};
    b_ext = {{(ACC_W-DW){signed_mode & b[DW-1]}}, b};
    sum_c = base + a_ext * b_ext;
  end
endmodule

// File: rtl/matmul_nxn_seq.sv
// Sequential NxN matrix multiplier: N MAC lanes update one row of C per clock, N*N clocks per product.
module matmul_nxn_seq
  import matmul_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  matmul_nxn_seq_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned AW = N * N * DW;
  localparam int unsigned CW = N * N * ACC_W;

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d, b_q, b_d;
  logic             sm_q, sm_d, am_q, am_d;
  logic [IW-1:0]    i_q, i_d, k_q, k_d;
  logic [CW-1:0]    c_q, c_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [ACC_W-1:0] sum_c [N];
  logic             last_c;

  assign last_c = (i_q == IW'(N-1)) && (k_q == IW'(N-1));

  // Lane j handles C[i][j] += A[i][k] * B[k][j]; base is zero on the first k of a fresh product.
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [DW-1:0]    a_c, b_c;
    logic [ACC_W-1:0] base_c;

    assign a_c    = a_q[flat_idx(32'(i_q), 32'(k_q), N) * DW +: DW];
    assign b_c    = b_q[flat_idx(32'(k_q), j, N) * DW +: DW];
    assign base_c = (k_q == '0 && !am_q) ? '0 : c_q[flat_idx(32'(i_q), j, N) * ACC_W +: ACC_W];

    matmul_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .a           (a_c),
      .b           (b_c),
      .base        (base_c),
      .signed_mode (sm_q),
      .sum_c       (sum_c[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      am_q    <= 1'b0;
      i_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      am_q    <= am_d;
      i_q     <= i_d;
      k_q     <= k_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_c)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept; lane write-back and i/k stepping while running.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sm_d   = sm_q;
    am_d   = am_q;
    i_d    = i_q;
    k_d    = k_q;
    c_d    = c_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d    = bus.A_flat;
          b_d    = bus.B_flat;
          sm_d   = bus.signed_mode;
          am_d   = bus.acc_mode;
          i_d    = '0;
          k_d    = '0;
          busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < N; j++) begin
          c_d[flat_idx(32'(i_q), j, N) * ACC_W +: ACC_W] = sum_c[j];
        end
        if (k_q == IW'(N-1)) begin
          k_d = '0;
          i_d = last_c ? '0 : i_q + IW'(1);
        end else begin
          k_d = k_q + IW'(1);
        end
        if (last_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.C_flat = c_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
